// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and sweep helpers for the LED PWM scheduler
package led_pkg;

  localparam int         LED_COUNT = 8;
  localparam logic [7:0] PWM_MAX   = 8'd255;

  localparam logic [1:0] PH_FILL  = 2'd0;
  localparam logic [1:0] PH_CLEAR = 2'd1;
  localparam logic [1:0] PH_HOLD  = 2'd2;

  typedef struct packed {
    logic [1:0] phase;
    logic [2:0] idx;
  } sweep_pos_t;

  // idx wraps 7->0 naturally; the phase flips FILL<->CLEAR on that wrap
  function automatic sweep_pos_t sweep_advance(input sweep_pos_t cur);
    sweep_pos_t nxt;
    nxt.idx   = cur.idx + 3'd1;
    nxt.phase = cur.phase;
    if (cur.idx == 3'd7) begin
      nxt.phase = (cur.phase == PH_FILL) ? PH_CLEAR : PH_FILL;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/led_pwm_bank.sv
// rtl/led_pwm_bank.sv - 8x8 brightness registers with one write port and registered PWM compare
import led_pkg::*;

module led_pwm_bank (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [2:0]           addr,
  input  logic [7:0]           data,
  output logic [LED_COUNT-1:0] leds
);

  logic [7:0] bright [LED_COUNT];
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
      leds    <= '0;
      for (int i = 0; i < LED_COUNT; i++) begin
        bright[i] <= 8'd0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (we) begin
        bright[addr] <= data;
      end
      for (int i = 0; i < LED_COUNT; i++) begin
        leds[i] <= (pwm_cnt < bright[i]);
      end
    end
  end

endmodule

// File: rtl/led_sweep_scheduler.sv
// rtl/led_sweep_scheduler.sv - step timer, sweep FSM and host/auto write arbiter for the LED bank
import led_pkg::*;

module led_sweep_scheduler #(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int STEP_CYCLES = 50_000_000,
  parameter int HOLD_TICKS  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       auto_en,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic [2:0] host_chan,
  input  logic [7:0] host_level,
  output logic [1:0] phase,
  output logic [7:0] leds
);

  localparam int              CW        = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0]   STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam bit              HOLD_ON   = (HOLD_TICKS > 0);
  localparam logic [15:0]     HOLD_INIT = 16'(HOLD_TICKS);

  if (STEP_CYCLES < 2 || CLK_FREQ <= 0) begin : g_bad_cfg
    $error("led_sweep_scheduler: STEP_CYCLES must be >= 2 and CLK_FREQ positive");
  end

  logic [CW-1:0] step_cnt;
  logic [1:0]    saved_phase;
  logic [2:0]    idx;
  logic [15:0]   hold_cnt;
  logic          auto_pend;
  logic          pend_hold;

  logic          tick;
  logic          accept;
  logic          sweep_tick;
  logic [7:0]    auto_level;
  sweep_pos_t    nxt;
  logic          bank_we;
  logic [2:0]    bank_addr;
  logic [7:0]    bank_data;

  always_comb begin
    tick       = auto_en && (step_cnt == STEP_LAST);
    host_ready = !auto_pend;
    accept     = host_valid && !auto_pend;
    sweep_tick = tick && (phase != PH_HOLD);
    auto_level = (phase == PH_FILL) ? PWM_MAX : 8'd0;
    nxt        = sweep_advance({phase, idx});
    // A pended auto write still targets the current idx/phase: neither moves until it retires
    bank_we    = accept || auto_pend || sweep_tick;
    bank_addr  = accept ? host_chan  : idx;
    bank_data  = accept ? host_level : auto_level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt    <= '0;
      phase       <= PH_FILL;
      saved_phase <= PH_FILL;
      idx         <= 3'd0;
      hold_cnt    <= 16'd0;
      auto_pend   <= 1'b0;
      pend_hold   <= 1'b0;
    end else begin
      if (!auto_en || (accept && HOLD_ON) || tick) begin
        step_cnt <= '0;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end

      if (auto_pend) begin
        auto_pend <= 1'b0;
        idx       <= nxt.idx;
        phase     <= nxt.phase;
        if (pend_hold) begin
          saved_phase <= nxt.phase;
          phase       <= PH_HOLD;
          hold_cnt    <= HOLD_INIT;
        end
      end else if (accept) begin
        if (sweep_tick) begin
          auto_pend <= 1'b1;
          pend_hold <= HOLD_ON;
        end else if (HOLD_ON) begin
          hold_cnt <= HOLD_INIT;
          if (phase != PH_HOLD) begin
            saved_phase <= phase;
            phase       <= PH_HOLD;
          end
        end
      end else if (sweep_tick) begin
        idx   <= nxt.idx;
        phase <= nxt.phase;
      end else if (tick) begin
        if (hold_cnt == 16'd1) begin
          phase <= saved_phase;
        end else begin
          hold_cnt <= hold_cnt - 16'd1;
        end
      end
    end
  end

  led_pwm_bank u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we),
    .addr  (bank_addr),
    .data  (bank_data),
    .leds  (leds)
  );

endmodule

// File: tb/tb_led_sweep_scheduler.sv
// tb/tb_led_sweep_scheduler.sv - directed table, corner sequences and random run against a sweep model
module tb_led_sweep_scheduler;

  localparam int S = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       auto_en = 1'b0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [2:0] host_chan = 3'd0;
  logic [7:0] host_level = 8'd0;
  logic [1:0] phase;
  logic [7:0] leds;

  led_sweep_scheduler #(
    .CLK_FREQ    (25_000_000),
    .STEP_CYCLES (S),
    .HOLD_TICKS  (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .auto_en    (auto_en),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_chan  (host_chan),
    .host_level (host_level),
    .phase      (phase),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_bright();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = dut.u_bank.bright[i];
    return r;
  endfunction

  // Sweep modelled as a position 0..15 (0..7 fill ch, 8..15 clear ch) plus remaining hold ticks
  int         m_br [8];
  int         m_timer, m_pos, m_hold, m_pwm;
  bit         m_pend, m_pend_hold, m_acc;
  logic [7:0] m_leds;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_br[i] = 0;
    m_timer = 0; m_pos = 0; m_hold = 0; m_pwm = 0;
    m_pend = 0; m_pend_hold = 0; m_acc = 0; m_leds = 8'd0;
  endtask

  task automatic model_sweep_write();
    m_br[m_pos % 8] = (m_pos < 8) ? 255 : 0;
    m_pos = (m_pos + 1) % 16;
  endtask

  task automatic model_step();
    bit tick;
    for (int i = 0; i < 8; i++) m_leds[i] = (m_pwm < m_br[i]);
    m_pwm = (m_pwm + 1) % 256;
    m_acc = host_valid && !m_pend;
    tick  = auto_en && (m_timer == S - 1);
    if (m_pend) begin
      model_sweep_write();
      if (m_pend_hold) m_hold = H;
      m_pend = 0;
    end
    if (m_acc) m_br[host_chan] = int'(host_level);
    if (tick && m_hold == 0) begin
      if (m_acc) begin
        m_pend = 1;
        m_pend_hold = (H > 0);
      end else begin
        model_sweep_write();
      end
    end else if (tick && !m_acc) begin
      m_hold--;
    end
    if (m_acc && H > 0 && !m_pend) m_hold = H;
    if (!auto_en || (m_acc && H > 0) || tick) m_timer = 0;
    else m_timer++;
  endtask

  function automatic logic [63:0] model_bright();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(m_br[i]);
    return r;
  endfunction

  function automatic logic [1:0] model_phase();
    if (m_hold > 0) return 2'd2;
    return (m_pos < 8) ? 2'd0 : 2'd1;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_bright", dut_bright(), model_bright());
    check("model_phase", 64'(phase), 64'(model_phase()));
    check("model_ready", 64'(host_ready), 64'(!m_pend));
    check("model_leds", 64'(leds), 64'(m_leds));
  endtask

  typedef struct {
    int          edges;
    bit          ae;
    bit          hv;
    logic [2:0]  ch;
    logic [7:0]  lv;
    logic [63:0] br;
    logic [1:0]  ph;
    bit          rdy;
  } vec_t;

  vec_t vt [17];

  initial begin
    int cnt0, cnt1, cnt2, guard;

    vt[0]  = '{4,  1, 0, 3'd0, 8'd0,   64'h00000000_000000FF, 2'd0, 1'b1};
    vt[1]  = '{12, 1, 0, 3'd0, 8'd0,   64'h00000000_FFFFFFFF, 2'd0, 1'b1};
    vt[2]  = '{16, 1, 0, 3'd0, 8'd0,   64'hFFFFFFFF_FFFFFFFF, 2'd1, 1'b1};
    vt[3]  = '{4,  1, 0, 3'd0, 8'd0,   64'hFFFFFFFF_FFFFFF00, 2'd1, 1'b1};
    vt[4]  = '{7,  1, 0, 3'd0, 8'd0,   64'hFFFFFFFF_FFFF0000, 2'd1, 1'b1};
    vt[5]  = '{1,  1, 1, 3'd2, 8'd10,  64'hFFFFFFFF_FF0A0000, 2'd1, 1'b0};
    vt[6]  = '{1,  1, 0, 3'd0, 8'd0,   64'hFFFFFFFF_FF000000, 2'd2, 1'b1};
    vt[7]  = '{6,  1, 0, 3'd0, 8'd0,   64'hFFFFFFFF_FF000000, 2'd2, 1'b1};
    vt[8]  = '{1,  1, 0, 3'd0, 8'd0,   64'hFFFFFFFF_FF000000, 2'd1, 1'b1};
    vt[9]  = '{3,  1, 0, 3'd0, 8'd0,   64'hFFFFFFFF_FF000000, 2'd1, 1'b1};
    vt[10] = '{1,  1, 0, 3'd0, 8'd0,   64'hFFFFFFFF_00000000, 2'd1, 1'b1};
    vt[11] = '{20, 0, 0, 3'd0, 8'd0,   64'hFFFFFFFF_00000000, 2'd1, 1'b1};
    vt[12] = '{3,  1, 0, 3'd0, 8'd0,   64'hFFFFFFFF_00000000, 2'd1, 1'b1};
    vt[13] = '{1,  1, 0, 3'd0, 8'd0,   64'hFFFFFF00_00000000, 2'd1, 1'b1};
    vt[14] = '{1,  1, 1, 3'd5, 8'd128, 64'hFFFF8000_00000000, 2'd2, 1'b1};
    vt[15] = '{11, 1, 0, 3'd0, 8'd0,   64'hFFFF8000_00000000, 2'd1, 1'b1};
    vt[16] = '{1,  1, 0, 3'd0, 8'd0,   64'hFFFF0000_00000000, 2'd1, 1'b1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_leds", 64'(leds), 64'd0);
    check("reset_bright", dut_bright(), 64'd0);
    check("reset_phase", 64'(phase), 64'd0);
    check("reset_ready", 64'(host_ready), 64'd1);
    rst_n = 1'b1;

    foreach (vt[k]) begin
      auto_en    = vt[k].ae;
      host_valid = vt[k].hv;
      host_chan  = vt[k].ch;
      host_level = vt[k].lv;
      repeat (vt[k].edges) begin
        cycle();
        host_valid = 1'b0;
      end
      check($sformatf("vec%0d_bright", k), dut_bright(), vt[k].br);
      check($sformatf("vec%0d_phase", k), 64'(phase), 64'(vt[k].ph));
      check($sformatf("vec%0d_ready", k), 64'(host_ready), 64'(vt[k].rdy));
    end

    // Duty cycle with the sweep frozen
    auto_en = 1'b0;
    host_valid = 1'b1; host_chan = 3'd0; host_level = 8'd64;  cycle();
    host_valid = 1'b1; host_chan = 3'd1; host_level = 8'd0;   cycle();
    host_valid = 1'b1; host_chan = 3'd2; host_level = 8'd255; cycle();
    host_valid = 1'b0;
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    repeat (256) begin
      cycle();
      cnt0 += int'(leds[0]);
      cnt1 += int'(leds[1]);
      cnt2 += int'(leds[2]);
    end
    check("duty_64", 64'(cnt0), 64'd64);
    check("duty_0", 64'(cnt1), 64'd0);
    check("duty_255", 64'(cnt2), 64'd255);

    // Collide with a tick, then reset while the auto write is pending
    auto_en = 1'b1;
    guard = 0;
    while (!(m_timer == S - 1 && m_hold == 0) && guard < 200) begin
      cycle();
      guard++;
    end
    check("collision_reached", 64'(guard < 200), 64'd1);
    host_valid = 1'b1; host_chan = 3'd6; host_level = 8'd200;
    cycle();
    host_valid = 1'b0;
    check("pend_ready_low", 64'(host_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_leds", 64'(leds), 64'd0);
    check("async_bright", dut_bright(), 64'd0);
    check("async_phase", 64'(phase), 64'd0);
    check("async_ready", 64'(host_ready), 64'd1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cycle();
    check("restart_ch0", dut_bright(), 64'h00000000_000000FF);

    // Random host traffic and enable toggling
    for (int n = 0; n < 3000; n++) begin
      if (!host_valid || m_acc) begin
        host_valid = ($urandom_range(0, 5) == 0);
        host_chan  = 3'($urandom_range(0, 7));
        host_level = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 63) == 0) auto_en = !auto_en;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
